div_iter_axis: RTL and testbench



---
 rtl/div_iter_axis_pkg.sv | 11 +
 rtl/div_restore_step.sv | 16 +
 rtl/div_iter_axis.sv | 86 ++++++++
 tb/tb_div_iter_axis.sv | 133 +++++++++++++
 4 files changed

// File: rtl/div_iter_axis_pkg.sv
// div_iter_axis_pkg: shared FSM encoding and latency constant for the iterative divider.
package div_iter_axis_pkg;
  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_st_e;
  // Must equal WIDTH+1 so the issuing unit's cycle counter lines up with the result.
  localparam int DIV_CYCLES = 33;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one radix-2 restoring division step (shift in next dividend bit, trial subtract).
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] sh;
  // One extra bit keeps the shifted remainder exact for divisors above 2^(WIDTH-1).
  assign sh       = {rem, q_msb};
  assign q_bit    = sh >= {1'b0, divisor};
  assign rem_next = q_bit ? WIDTH'(sh - {1'b0, divisor}) : sh[WIDTH-1:0];
endmodule

// File: rtl/div_iter_axis.sv
// div_iter_axis: AXI-Stream radix-2 restoring divider, fixed WIDTH+1 cycle latency, signed or unsigned.
module div_iter_axis
  import div_iter_axis_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready
);
  localparam int CW = $clog2(WIDTH);
  div_st_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, q, dvs, raw, rem_step, a_mag, b_mag, q_fix, r_fix;
  logic sa, sb, dz, sa_in, sb_in, q_bit, take, idle;
  assign idle  = state == DIV_ST_IDLE;
  assign take  = idle & s_axis_divisor_tvalid & s_axis_dividend_tvalid;
  assign s_axis_divisor_tready  = rst_n & idle & s_axis_dividend_tvalid;
  assign s_axis_dividend_tready = rst_n & idle & s_axis_divisor_tvalid;
  assign m_axis_dout_tvalid     = state == DIV_ST_DONE;
  assign sa_in = SIGNED & s_axis_dividend_tdata[WIDTH-1];
  assign sb_in = SIGNED & s_axis_divisor_tdata[WIDTH-1];
  assign a_mag = sa_in ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign b_mag = sb_in ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
  // MIN_INT / -1 needs no special case: the magnitude quotient 2^(WIDTH-1) reads back as MIN_INT.
  assign q_fix = dz ? {WIDTH{1'b1}} : (sa ^ sb) ? -q : q;
  assign r_fix = dz ? raw : sa ? -rem : rem;
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .q_msb   (q[WIDTH-1]),
    .divisor (dvs),
    .rem_next(rem_step),
    .q_bit   (q_bit)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_ST_IDLE: state_nxt = take ? DIV_ST_CALC : DIV_ST_IDLE;
      DIV_ST_CALC: state_nxt = (cnt == CW'(WIDTH-1)) ? DIV_ST_FIX : DIV_ST_CALC;
      DIV_ST_FIX:  state_nxt = DIV_ST_DONE;
      DIV_ST_DONE: state_nxt = m_axis_dout_tready ? DIV_ST_IDLE : DIV_ST_DONE;
      default:     state_nxt = DIV_ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= DIV_ST_IDLE;
      cnt               <= '0;
      rem               <= '0;
      q                 <= '0;
      dvs               <= '0;
      raw               <= '0;
      sa                <= 1'b0;
      sb                <= 1'b0;
      dz                <= 1'b0;
      m_axis_dout_tdata <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        q   <= a_mag;
        dvs <= b_mag;
        raw <= s_axis_dividend_tdata;
        sa  <= sa_in;
        sb  <= sb_in;
        dz  <= s_axis_divisor_tdata == '0;
        rem <= '0;
        cnt <= '0;
      end else if (state == DIV_ST_CALC) begin
        rem <= rem_step;
        q   <= {q[WIDTH-2:0], q_bit};
        cnt <= cnt + 1'b1;
      end else if (state == DIV_ST_FIX) begin
        m_axis_dout_tdata <= {q_fix, r_fix};
      end
    end
  end
endmodule

// File: tb/tb_div_iter_axis.sv
// tb_div_iter_axis: directed vectors run through unsigned and signed instances side by side.
module tb_div_iter_axis;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] dvs_d = '0, dvd_d = '0;
  logic dvs_v = 1'b0, dvd_v = 1'b0, m_rdy = 1'b1;
  logic u_dvs_r, u_dvd_r, u_v, s_dvs_r, s_dvd_r, s_v;
  logic [63:0] u_d, s_d;
  int checks = 0;
  int errors = 0;

  div_iter_axis #(.WIDTH(32), .SIGNED(1'b0)) u_u (
    .clk(clk), .rst_n(rst_n),
    .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(u_dvs_r),
    .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(u_dvd_r),
    .m_axis_dout_tdata(u_d), .m_axis_dout_tvalid(u_v), .m_axis_dout_tready(m_rdy)
  );
  div_iter_axis #(.WIDTH(32), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n),
    .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(s_dvs_r),
    .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(s_dvd_r),
    .m_axis_dout_tdata(s_d), .m_axis_dout_tvalid(s_v), .m_axis_dout_tready(m_rdy)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_op(input string n, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] eu, input logic [63:0] es, input int hold);
    int lat = 0;
    @(negedge clk);
    dvd_d = a; dvs_d = b; dvd_v = 1'b1; dvs_v = 1'b1; m_rdy = (hold == 0);
    #1;
    chk({n, " s_tready"}, 64'({u_dvs_r, u_dvd_r, s_dvs_r, s_dvd_r}), 64'hF);
    @(posedge clk);
    #1;
    dvd_v = 1'b0; dvs_v = 1'b0;
    while (!(u_v && s_v) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({n, " latency"}, 64'(lat), 64'd33);
    chk({n, " unsigned"}, u_d, eu);
    chk({n, " signed"}, s_d, es);
    if (hold > 0) begin
      dvd_v = 1'b1; dvs_v = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk({n, " hold tvalid"}, 64'({u_v, s_v}), 64'h3);
        chk({n, " hold tdata"}, u_d, eu);
        chk({n, " hold s_tready"}, 64'({u_dvs_r, u_dvd_r, s_dvs_r, s_dvd_r}), 64'h0);
      end
      dvd_v = 1'b0; dvs_v = 1'b0; m_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({n, " tvalid cleared"}, 64'({u_v, s_v}), 64'h0);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [63:0] eu, es;
    int hold;
  } vec_t;
  vec_t v[9];

  initial begin
    int seen;
    v[0] = '{32'd100,       32'd7,         {32'd14, 32'd2},                   {32'd14, 32'd2},                   0};
    v[1] = '{32'hFFFFFFF9,  32'h2,         {32'h7FFFFFFC, 32'h1},             {32'hFFFFFFFD, 32'hFFFFFFFF},      0};
    v[2] = '{32'h7,         32'hFFFFFFFE,  {32'h0, 32'h7},                    {32'hFFFFFFFD, 32'h1},             0};
    v[3] = '{32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000},             {32'h80000000, 32'h0},             0};
    v[4] = '{32'hFFFFFFFF,  32'h1,         {32'hFFFFFFFF, 32'h0},             {32'hFFFFFFFF, 32'h0},             0};
    v[5] = '{32'h12345678,  32'h0,         {32'hFFFFFFFF, 32'h12345678},      {32'hFFFFFFFF, 32'h12345678},      0};
    v[6] = '{32'hFFFFFFFE,  32'h80000000,  {32'h1, 32'h7FFFFFFE},             {32'h0, 32'hFFFFFFFE},             0};
    v[7] = '{32'd1000,      32'hFFFFFFF9,  {32'h0, 32'h3E8},                  {32'hFFFFFF72, 32'h6},             0};
    v[8] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  {32'h1, 32'h0},                    {32'h1, 32'h0},                    5};
    dvd_v = 1'b1; dvs_v = 1'b1;
    #2;
    chk("reset tvalid", 64'({u_v, s_v}), 64'h0);
    chk("reset tdata u", u_d, 64'h0);
    chk("reset tdata s", s_d, 64'h0);
    chk("reset s_tready", 64'({u_dvs_r, u_dvd_r, s_dvs_r, s_dvd_r}), 64'h0);
    dvd_v = 1'b0; dvs_v = 1'b0;
    #21 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) do_op($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].eu, v[i].es, v[i].hold);
    // A lone divisor valid must never be consumed.
    @(negedge clk);
    dvs_d = 32'd5; dvd_d = 32'd50; dvs_v = 1'b1;
    repeat (10) begin
      #1;
      chk("lone divisor_tready", 64'({u_dvs_r, s_dvs_r}), 64'h0);
      @(negedge clk);
    end
    dvs_v = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (u_v || s_v) seen = 1;
    end
    chk("lone divisor no result", 64'(seen), 64'h0);
    // Asynchronous reset in the middle of the iteration.
    @(negedge clk);
    dvd_d = 32'd100; dvs_d = 32'd7; dvd_v = 1'b1; dvs_v = 1'b1; m_rdy = 1'b1;
    @(posedge clk);
    #1;
    dvd_v = 1'b0; dvs_v = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset tvalid", 64'({u_v, s_v}), 64'h0);
    chk("midreset tdata u", u_d, 64'h0);
    chk("midreset tdata s", s_d, 64'h0);
    dvd_v = 1'b1; dvs_v = 1'b1;
    #1;
    chk("midreset s_tready", 64'({u_dvs_r, u_dvd_r, s_dvs_r, s_dvd_r}), 64'h0);
    dvd_v = 1'b0; dvs_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after reset 9/3", 32'd9, 32'd3, {32'd3, 32'd0}, {32'd3, 32'd0}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
